// File: rtl/even_div_ctrl.sv
// -----------------------------------------------------------------------------
// even_div_ctrl
//
// Runtime-programmable even clock divider with a glitch-free controller.
// clk_out = clk_in / (2*N), where N is a half-period in clk_in cycles.
// The first high phase after IDLE is exactly N cycles. Stopping always
// finishes the current period. Ratio changes take effect only at a period
// boundary, which is the cycle in which clk_out goes 0->1.
//
// Parameters:
//   CNT_W     width of the half-period config and the phase counter
//             (legal N = 1 .. 2^CNT_W-1)
//   RST_HALF  half-period in force after reset
//
// Ports:
//   clk_in     in   system clock; all logic runs on its rising edge
//   rst        in   asynchronous active-low reset
//   en         in   level: 1 = run, 0 = stop at the next period boundary
//   cfg_valid  in   a new half-period is offered on cfg_half
//   cfg_half   in   requested N; 0 is illegal
//   cfg_ready  out  the controller can accept a config
//   cfg_err    out  one-cycle pulse: an illegal config (N=0) was dropped
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse in the cycle clk_out goes 0->1
//   busy       out  1 whenever the controller is not IDLE
//   prd_cnt    out  [15:0] tick counter; present only when
//                   EVEN_DIV_CTRL_PRD_CNT_EN is defined
//
// Optional feature macro: EVEN_DIV_CTRL_PRD_CNT_EN
//
// Config handshake: a transfer happens in a cycle where cfg_valid and
// cfg_ready are both 1 at the rising edge. cfg_ready is 1 exactly when no
// config is pending. cfg_valid may be held or dropped freely; nothing is
// taken unless cfg_ready is 1.
// -----------------------------------------------------------------------------
module even_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int RST_HALF = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
    ,
    output logic [15:0]      prd_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_HALF_V = CNT_W'(RST_HALF);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] pend_half;
    logic             pending;

    logic cfg_fire;
    logic phase_end;

    assign cfg_ready = !pending;
    assign busy      = (state != IDLE);
    assign cfg_fire  = cfg_valid && !pending;
    // Only the active half-period sets the phase length; a pending value
    // never shortens or stretches the phase in progress.
    assign phase_end = (cnt == (active_half - ONE));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            cfg_err     <= 1'b0;
            active_half <= RST_HALF_V;
            pend_half   <= '0;
            pending     <= 1'b0;
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
            prd_cnt     <= '0;
`endif
        end else begin
            tick    <= 1'b0;
            cfg_err <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    // A config that became pending on the STOP->IDLE edge
                    // lands here, so IDLE never sits on a pending value.
                    if (pending) begin
                        active_half <= pend_half;
                        pending     <= 1'b0;
                    end
                    if (en) begin
                        state   <= RUN;
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
                        prd_cnt <= prd_cnt + 16'd1;
`endif
                    end
                end

                RUN, STOP: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (clk_out) begin
                            clk_out <= 1'b0;
                        end else begin
                            // Period boundary: the new ratio must already
                            // govern the high phase that starts here.
                            if (pending) begin
                                active_half <= pend_half;
                                pending     <= 1'b0;
                            end
                            if (state == RUN) begin
                                clk_out <= 1'b1;
                                tick    <= 1'b1;
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
                                prd_cnt <= prd_cnt + 16'd1;
`endif
                            end else begin
                                // Suppress the rising edge: last period done.
                                state <= IDLE;
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
                                prd_cnt <= '0;
`endif
                            end
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                    // en is ignored once STOP has begun.
                    if (state == RUN && !en) begin
                        state <= STOP;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase

            // A transfer needs pending==0, so it never collides with the
            // pending-apply paths above.
            if (cfg_fire) begin
                if (cfg_half == '0) begin
                    cfg_err <= 1'b1;
                end else if (state == IDLE) begin
                    active_half <= cfg_half;
                end else begin
                    pend_half <= cfg_half;
                    pending   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_even_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_even_div_ctrl
//
// Self-checking bench for even_div_ctrl. Output vector checked each cycle is
// {clk_out, tick, cfg_ready, cfg_err, busy}.
// -----------------------------------------------------------------------------
module tb_even_div_ctrl;

    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             busy;
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
    logic [15:0]      prd_cnt;
`endif

    always #5 clk_in = ~clk_in;

    even_div_ctrl #(.CNT_W(CNT_W), .RST_HALF(1)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
`ifdef EVEN_DIV_CTRL_PRD_CNT_EN
        ,
        .prd_cnt   (prd_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             en;
        logic             v;
        logic [CNT_W-1:0] h;
        logic [4:0]       exp;
    } tv_t;

    tv_t tv[$];

    function automatic tv_t mk(input logic e, input logic v,
                               input logic [CNT_W-1:0] h, input logic [4:0] exp);
        tv_t r;
        r.en  = e;
        r.v   = v;
        r.h   = h;
        r.exp = exp;
        return r;
    endfunction

    function automatic logic [4:0] outs();
        return {clk_out, tick, cfg_ready, cfg_err, busy};
    endfunction

    task automatic chk(input string name, input int idx, input logic [4:0] exp);
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got {clk,tick,rdy,err,busy}=%b expected %b",
                     name, idx, outs(), exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs for one rising edge, then return at the following
    // falling edge where outputs are sampled.
    task automatic cyc(input logic e, input logic v, input logic [CNT_W-1:0] h);
        en        = e;
        cfg_valid = v;
        cfg_half  = h;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        rst       = 1'b0;
        repeat (2) @(negedge clk_in);
        rst = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        // Table: default N=1 run and stop, idle config N=3, N=3->5 change.
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 0  en -> first high, tick
        tv.push_back(mk(1, 0, 0, 5'b00101)); // 1
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 2
        tv.push_back(mk(1, 0, 0, 5'b00101)); // 3
        tv.push_back(mk(0, 0, 0, 5'b11101)); // 4  en=0 on boundary: tick still
        tv.push_back(mk(0, 0, 0, 5'b00101)); // 5  STOP, low phase
        tv.push_back(mk(0, 0, 0, 5'b00100)); // 6  rising edge suppressed, IDLE
        tv.push_back(mk(0, 0, 0, 5'b00100)); // 7
        tv.push_back(mk(0, 1, 3, 5'b00100)); // 8  idle config N=3
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 9
        tv.push_back(mk(1, 0, 0, 5'b10101)); // 10
        tv.push_back(mk(1, 0, 0, 5'b10101)); // 11
        tv.push_back(mk(1, 0, 0, 5'b00101)); // 12
        tv.push_back(mk(1, 0, 0, 5'b00101)); // 13
        tv.push_back(mk(1, 0, 0, 5'b00101)); // 14
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 15 tick period 6
        tv.push_back(mk(1, 1, 5, 5'b10001)); // 16 N=5 pending mid high
        tv.push_back(mk(1, 0, 0, 5'b10001)); // 17
        tv.push_back(mk(1, 0, 0, 5'b00001)); // 18 old N=3 still in force
        tv.push_back(mk(1, 0, 0, 5'b00001)); // 19
        tv.push_back(mk(1, 0, 0, 5'b00001)); // 20
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 21 boundary: apply, ready back
        for (int i = 0; i < 4; i++) tv.push_back(mk(1, 0, 0, 5'b10101)); // 22-25
        for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 0, 5'b00101)); // 26-30
        tv.push_back(mk(1, 0, 0, 5'b11101)); // 31 period 10

        do_reset();
        // Reset state is checked while reset is still held.
        rst = 1'b0;
        #1;
        chk("reset_held", 0, 5'b00100);
        @(negedge clk_in);
        rst = 1'b1;

        foreach (tv[i]) begin
            cyc(tv[i].en, tv[i].v, tv[i].h);
            chk("vec", i, tv[i].exp);
        end

        // cfg_half=0 while running N=2: dropped, one-cycle error, period 4.
        do_reset();
        cyc(0, 1, 2);
        cyc(1, 0, 0);
        chk("err_start", 0, 5'b11101);
        for (int k = 1; k < 12; k++) begin
            cyc(1, (k == 3), 0);
            chk("err_run", k, {((k % 4) < 2), ((k % 4) == 0), 1'b1, (k == 3), 1'b1});
        end

        // Stop with N=4, en=0 on cycle 1 of the high phase.
        do_reset();
        cyc(0, 1, 4);
        cyc(1, 0, 0);
        chk("stop_start", 0, 5'b11101);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0);
            chk("stop", k, {(k <= 3), 1'b0, 1'b1, 1'b0, (k <= 7)});
        end

        // Reset mid low phase with N=7 pending; afterwards N=1 again.
        do_reset();
        cyc(0, 1, 2);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 7);
        chk("rst_pend", 0, 5'b00001);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async", 0, 5'b00100);
        @(negedge clk_in);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            chk("rst_after", k, {(k % 2 == 0), (k % 2 == 0), 1'b1, 1'b0, 1'b1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/even_div_ctrl.md
Name: even_div_ctrl

Overview:
- Runtime-programmable even clock divider with a controller around it. Generates `clk_out` = `clk_in` / (2*N), where N is a programmable half-period in `clk_in` cycles.
- Sequences enable/disable and ratio changes so that `clk_out` never produces a runt or glitched phase.
- Sits beside the fixed /2 /4 /8 dividers and serves blocks needing a software-selected even ratio.
- Configuration uses a valid/ready handshake.

Parameters:
- CNT_W, 8, width of half-period config and phase counter; legal N = 1 .. 2^CNT_W-1
- RST_HALF, 1, half-period N in force after reset (divide-by-2)

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- en  input  1  level; 1 = run divided clock, 0 = stop at period boundary
- cfg_valid  input  1  new half-period offered
- cfg_half  input  CNT_W  requested N; 0 is illegal
- cfg_ready  output  1  controller can accept a config
- cfg_err  output  1  one-cycle pulse: illegal config (N=0) was dropped
- clk_out  output  1  divided clock, registered
- tick  output  1  one-cycle pulse in the cycle `clk_out` goes 0->1
- busy  output  1  1 whenever state != IDLE

Behaviour:
- Clocking and reset:
  - Single clock `clk_in`.
  - `rst` is asynchronous, active-low.
  - Reset values: state=IDLE, `clk_out`=0, `tick`=0, `cfg_err`=0, `cfg_ready`=1, `busy`=0, counter=0, active half=RST_HALF, pending flag=0.
  - Reset asserted mid-operation returns everything to these values immediately; any pending config is lost.
- States: IDLE, RUN, STOP.
- IDLE:
  - `clk_out`=0, counter held at 0.
  - If en=1: next cycle go to RUN, `clk_out`<=1, `tick`=1 that cycle, counter<=0.
- RUN, each cycle:
  - If counter==active_half-1: counter<=0 and `clk_out` toggles.
  - Otherwise counter increments.
  - Period boundary = the cycle `clk_out` toggles 0->1.
- RUN -> STOP: when en=0 is sampled.
- STOP:
  - Keeps counting with the same toggle rule until the low phase completes.
  - At the cycle the 0->1 toggle would occur: `clk_out` stays 0 and state goes to IDLE.
  - Effect: the last period is always complete.
  - en is ignored while in STOP.
- Resulting waveform: high phase N cycles, low phase N cycles. First high phase after IDLE is exactly N cycles.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - `cfg_ready` = !pending.
  - cfg_half=0: transfer completes, config is dropped, `cfg_err`=1 the next cycle.
  - In IDLE: a legal config loads active_half directly the next cycle.
  - In RUN/STOP: a legal config is stored as pending and `cfg_ready` drops.
  - Pending is applied at the next period boundary. The high phase starting at that boundary already uses the new N.
  - If STOP reaches IDLE with pending set, pending is applied on entry to IDLE.
- Simultaneous events:
  - Config handshake in the same cycle as a boundary: the config becomes pending and takes effect at the following boundary, not the current one.
  - en=0 and a boundary in the same cycle: the boundary completes normally (`tick`=1); STOP begins next cycle.
  - Pending config and en 1->0 together: both honoured as above.
- Counter comparison uses active_half only, never the pending value.

Optional Feature:
- Macro: EVEN_DIV_CTRL_PRD_CNT_EN.
- Defined:
  - Adds output prd_cnt [15:0], reset 0.
  - Increments on every `tick`; wraps 0xFFFF->0.
  - Clears when state enters IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, en=1, default N=1 -> `clk_out` toggles every cycle starting high the cycle after en; `tick` every 2 cycles; `busy`=1.
- In IDLE, cfg_half=3 handshake, then en=1 -> `clk_out` high 3 / low 3 cycles repeatedly; `tick` period 6.
- Running N=3, cfg_half=5 mid high phase:
  - `cfg_ready`=0 until the next boundary.
  - Remaining phases stay at 3; from that boundary, phases are 5/5.
  - `cfg_ready`=1 the cycle after apply.
- cfg_half=0 offered while running N=2 -> handshake completes, `cfg_err`=1 for exactly one cycle, period unchanged at 4.
- Running N=4, en=0 on cycle 1 of the high phase -> remaining high phase plus 4 low cycles complete; `clk_out` stays 0; `busy`=0 at the boundary; no extra `tick`.
- Reset asserted mid low phase with a pending N=7 -> outputs at reset values at once; after release and en=1, period is RST_HALF-based (2 cycles).
